// File: rtl/bin_xs3_pkg.sv
// Shared types and constants for the sequential binary to BCD / excess-3 converter.
// Defining XS3_GRAY_EN switches out_xs3 to excess-3 Gray code per digit.
package bin_xs3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] XS3_BIAS      = 4'd3;
    localparam logic [3:0] DABBLE_THRESH = 4'd5;

    function automatic logic [3:0] xs3_gray(input logic [3:0] x);
        return x ^ (x >> 1);
    endfunction

endpackage

// File: rtl/bin_xs3_seq_cell.sv
// Double-dabble correction cell: one BCD digit gets +3 when it is >= 5,
// so that the following left shift carries correctly into the next digit.
module bcd_dabble_cell
    import bin_xs3_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= DABBLE_THRESH) ? d + XS3_BIAS : d;

endmodule

// File: rtl/bin_xs3_seq.sv
// Iterative binary to BCD and excess-3 converter, one input bit per clock.
// Build option XS3_GRAY_EN: out_xs3 carries excess-3 Gray code per digit.
module bin_xs3_seq
    import bin_xs3_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [4*DIGITS-1:0]   out_xs3,
    output logic                  out_ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    state_t          state_q;
    state_t          state_d;
    logic [WIDTH-1:0] bin_sr;
    logic [BW-1:0]   bcd_sr;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   nxt_bcd;
    logic [BW-1:0]   xs3_nxt;
    logic [CW-1:0]   cnt;
    logic            ovf;
    logic            shift_out;
    logic            last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        bcd_dabble_cell u_cell (
            .d (bcd_sr[4*g +: 4]),
            .q (adj[4*g +: 4])
        );
    end

    assign shift_out = adj[BW-1];
    assign nxt_bcd   = {adj[BW-2:0], bin_sr[WIDTH-1]};
    assign last      = (cnt == CW'(1));

    always_comb begin
        xs3_nxt = '0;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef XS3_GRAY_EN
            xs3_nxt[4*i +: 4] = xs3_gray(nxt_bcd[4*i +: 4] + XS3_BIAS);
`else
            xs3_nxt[4*i +: 4] = nxt_bcd[4*i +: 4] + XS3_BIAS;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Results are captured on the final shift so they stay frozen through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            bcd_sr  <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_bcd <= '0;
            out_xs3 <= '0;
            out_ovf <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr <= in_data;
                        bcd_sr <= '0;
                        ovf    <= 1'b0;
                        cnt    <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    bin_sr <= bin_sr << 1;
                    bcd_sr <= nxt_bcd;
                    ovf    <= ovf | shift_out;
                    cnt    <= cnt - CW'(1);
                    if (last) begin
                        out_bcd <= nxt_bcd;
                        out_xs3 <= xs3_nxt;
                        out_ovf <= ovf | shift_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_xs3_seq.sv
// Self-checking bench for bin_xs3_seq: decimal reference model plus directed vectors.
// A DIGITS=2 instance shares the stimulus to exercise the overflow path.
module tb_bin_xs3_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, out_valid, out_ovf;
    logic [11:0] out_bcd, out_xs3;
    logic        in_ready2, out_valid2, out_ovf2;
    logic [7:0]  out_bcd2, out_xs32;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bin_xs3_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_xs3(out_xs3), .out_ovf(out_ovf)
    );

    bin_xs3_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_bcd(out_bcd2), .out_xs3(out_xs32), .out_ovf(out_ovf2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] bcd_of(input int v, input int nd);
        logic [11:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] xs3_of(input logic [11:0] b, input int nd);
        logic [11:0] r;
        logic [3:0]  x;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            x = b[4*i +: 4] + 4'd3;
`ifdef XS3_GRAY_EN
            x = x ^ (x >> 1);
`endif
            r[4*i +: 4] = x;
        end
        return r;
    endfunction

    function automatic logic ovf_of(input int v, input int nd);
        int p;
        p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        return v >= p;
    endfunction

    // Reference: accept when idle, result appears 8 edges later, held until ack.
    int          m_val = 0;
    int          m_cnt = 0;
    logic        m_idle = 1'b1;
    logic        m_done = 1'b0;
    logic [11:0] e_bcd = '0, e_xs3 = '0;
    logic [7:0]  e_bcd2 = '0, e_xs32 = '0;
    logic        e_ovf = 1'b0, e_ovf2 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1; m_done <= 1'b0; m_cnt <= 0;
            e_bcd <= '0; e_xs3 <= '0; e_ovf <= 1'b0;
            e_bcd2 <= '0; e_xs32 <= '0; e_ovf2 <= 1'b0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_val  <= int'(in_data);
                m_cnt  <= 8;
                m_idle <= 1'b0;
            end
        end else if (!m_done) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                e_bcd  <= bcd_of(m_val, 3);
                e_xs3  <= xs3_of(bcd_of(m_val, 3), 3);
                e_ovf  <= ovf_of(m_val, 3);
                e_bcd2 <= 8'(bcd_of(m_val, 2));
                e_xs32 <= 8'(xs3_of(bcd_of(m_val, 2), 2));
                e_ovf2 <= ovf_of(m_val, 2);
            end
        end else if (out_ready) begin
            m_done <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(m_idle));
            chk("out_valid", 32'(out_valid), 32'(m_done));
            chk("out_bcd", 32'(out_bcd), 32'(e_bcd));
            chk("out_xs3", 32'(out_xs3), 32'(e_xs3));
            chk("out_ovf", 32'(out_ovf), 32'(e_ovf));
            chk("in_ready2", 32'(in_ready2), 32'(m_idle));
            chk("out_valid2", 32'(out_valid2), 32'(m_done));
            chk("out_bcd2", 32'(out_bcd2), 32'(e_bcd2));
            chk("out_xs32", 32'(out_xs32), 32'(e_xs32));
            chk("out_ovf2", 32'(out_ovf2), 32'(e_ovf2));
        end
    end

    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        in_data  = v;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'(n), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) chk("valid_timeout", 32'(lat), 32'(8));
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int c0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_bcd", 32'(out_bcd), 32'h0);
        chk("rst_out_xs3", 32'(out_xs3), 32'h0);
        chk("rst_out_ovf", 32'(out_ovf), 32'(0));

        send(8'd0);
        wait_valid(lat);
        chk("lat_0", 32'(lat), 32'(8));
        chk("bcd_0", 32'(out_bcd), 32'h000);
`ifdef XS3_GRAY_EN
        chk("xs3_0", 32'(out_xs3), 32'h222);
`else
        chk("xs3_0", 32'(out_xs3), 32'h333);
`endif
        chk("ovf_0", 32'(out_ovf), 32'(0));
        ack();

        send(8'd255);
        wait_valid(lat);
        chk("lat_255", 32'(lat), 32'(8));
        chk("bcd_255", 32'(out_bcd), 32'h255);
`ifdef XS3_GRAY_EN
        chk("xs3_255", 32'(out_xs3), 32'h7CC);
`else
        chk("xs3_255", 32'(out_xs3), 32'h588);
`endif
        chk("ovf_255", 32'(out_ovf), 32'(0));
        chk("d2_bcd_255", 32'(out_bcd2), 32'h55);
        chk("d2_ovf_255", 32'(out_ovf2), 32'(1));
        ack();

        send(8'd137);
        wait_valid(lat);
        in_data  = 8'd55;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_bcd", 32'(out_bcd), 32'h137);
            chk("hold_in_ready", 32'(in_ready), 32'(0));
        end
        in_valid = 1'b0;
        ack();
        chk("post_ack_ready", 32'(in_ready), 32'(1));

        send(8'd100);
        wait_valid(lat);
        chk("bcd_100", 32'(out_bcd), 32'h100);
        chk("d2_bcd_100", 32'(out_bcd2), 32'h00);
        chk("d2_ovf_100", 32'(out_ovf2), 32'(1));
        ack();

        send(8'd99);
        wait_valid(lat);
        chk("d2_bcd_99", 32'(out_bcd2), 32'h99);
        chk("d2_ovf_99", 32'(out_ovf2), 32'(0));
        ack();

        out_ready = 1'b1;
        c0 = cyc;
        for (int v = 0; v < 256; v++) send(8'(v));
        chk("sweep_cycles", 32'(cyc - c0), 32'(2551));
        wait_valid(lat);
        @(posedge clk); #1;
        out_ready = 1'b0;

        send(8'd200);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'(1));
        chk("arst_out_valid", 32'(out_valid), 32'(0));
        chk("arst_out_bcd", 32'(out_bcd), 32'h0);
        chk("arst_out_xs3", 32'(out_xs3), 32'h0);
        chk("arst_out_ovf", 32'(out_ovf), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(8'd42);
        wait_valid(lat);
        chk("lat_42", 32'(lat), 32'(8));
        chk("bcd_42", 32'(out_bcd), 32'h042);
        ack();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_xs3_seq.md
Name: bin_xs3_seq

Overview:
Parametrised sequential binary-to-BCD and excess-3 converter using iterative double-dabble (shift-and-add-3), one input bit per clock. Accepts a WIDTH-bit unsigned word over a valid/ready handshake. Returns DIGITS packed BCD digits and the matching excess-3 digits, plus an overflow flag. Successor to the fixed 4-bit combinational excess-3 converter in the computer-architecture lab set.

Parameters:
WIDTH, 8, binary input width (>=1)
DIGITS, 3, number of 4-bit output digits (>=1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data valid
in_ready  out  1  converter can accept a word
in_data  in  WIDTH  unsigned binary operand
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_bcd  out  4*DIGITS  packed BCD, digit 0 in [3:0]
out_xs3  out  4*DIGITS  packed excess-3 (BCD digit + 3 per digit)
out_ovf  out  1  value does not fit in DIGITS decimal digits

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE; in_ready=1; out_valid=0; out_bcd=0; out_xs3=0; out_ovf=0; internal shift register and counter = 0. Reset asserted mid-conversion aborts it; the result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready: latch in_data into bin_sr, clear bcd_sr and ovf, set cnt=WIDTH, go to SHIFT.
- SHIFT: in_ready=0. Each cycle, in order:
  - every digit of bcd_sr >=5 gets +3;
  - {bcd_sr,bin_sr} shifts left 1;
  - the bit shifted out of the top digit ORs into sticky ovf;
  - cnt decrements.
  - When cnt==1 at the edge, go to DONE.
- DONE: out_valid=1; out_bcd, out_xs3 and out_ovf are stable and held until out_valid&&out_ready, then go to IDLE. in_ready=0 in DONE; there is no same-cycle overlap.
- Latency: handshake at edge N, out_valid high after edge N+WIDTH. Throughput: one word per WIDTH+2 cycles when out_ready is held high.
- Excess-3: each digit is BCD+4'd3. Digits are always <=9, so no wrap.
- Overflow: when out_ovf=1, out_bcd/out_xs3 hold the low DIGITS decimal digits (value mod 10^DIGITS).
- Inputs arriving while in_ready=0 are ignored.
- out_bcd and out_xs3 change only on entry to DONE or on reset.

Optional Feature:
XS3_GRAY_EN
- Defined: out_xs3 carries excess-3 Gray code per digit, g = x ^ (x>>1), applied to each xs3 digit x.
- Undefined: out_xs3 is plain excess-3.
- out_bcd and timing are identical in both builds.

Decomposition:
- Package bin_xs3_pkg holds:
  - state enum type (IDLE/SHIFT/DONE);
  - constant XS3_BIAS=4'd3 and DABBLE_THRESH=4'd5;
  - function xs3_gray(4-bit).
- One sub-module: bcd_dabble_cell, a combinational 4-bit add-3-if->=5 cell, instantiated DIGITS times in a generate loop.

Test Plan:
- in_data=0 -> after 8 cycles: out_bcd=12'h000, out_xs3=12'h333, out_ovf=0; with XS3_GRAY_EN, out_xs3=12'h222.
- in_data=255 -> out_bcd=12'h255, out_xs3=12'h588, out_ovf=0; out_valid rises exactly 8 edges after the handshake.
- Sweep 0..255 back-to-back with out_ready=1 -> every result matches the decimal model; in_ready=0 throughout SHIFT/DONE.
- in_data=137, out_ready held 0 for 5 cycles -> out_bcd=12'h137 and out_valid stay stable; a new in_valid is not accepted until after the out handshake.
- DIGITS=2, in_data=100 -> out_ovf=1, out_bcd=8'h00; in_data=99 -> out_ovf=0, out_bcd=8'h99.
- rst_n low at cycle 3 of SHIFT -> outputs 0, in_ready=1 immediately (async); the next conversion of 42 gives out_bcd=12'h042.
